pipe_ctrl_n: RTL

Parametrised pipeline-control unit for the CPU core. It generalises the fixed five-stage keep/throw/dirty control to any depth and adds per-stage occupancy tracking, a drain/halt handshake, and a saturating stall-cycle counter. It sits beside the stage registers. It turns per-stage stall, flush and extend requests into per-stage keep, throw and dirty controls for every stage register and for the PC register.

---
 rtl/pipe_ctrl_n_if.sv | 32 +++
 rtl/pipe_ctrl_n.sv | 95 +++++++++
 2 files changed

// File: rtl/pipe_ctrl_n_if.sv
// Request/control bundle between the pipeline stages and pipe_ctrl_n.
// The master side raises stall/flush/extend requests; the slave side returns keep/throw/dirty controls.
interface pipe_ctrl_n_if #(
    parameter int STAGES = 5,
    parameter int CNT_W  = 16
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic              src_valid;
    logic              halt_req;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] extend;
    logic [STAGES-1:0] flush;
    logic              cnt_clr;
    logic [STAGES-1:0] keep;
    logic [STAGES-1:0] throw;
    logic [STAGES-1:0] dirty_now;
    logic [STAGES-1:0] dirty;
    logic [OCC_W-1:0]  occupancy;
    logic              drained;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output src_valid, halt_req, stall, extend, flush, cnt_clr,
        input  keep, throw, dirty_now, dirty, occupancy, drained, stall_cnt
    );

    modport slave (
        input  src_valid, halt_req, stall, extend, flush, cnt_clr,
        output keep, throw, dirty_now, dirty, occupancy, drained, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_n.sv
// Pipeline keep/throw/dirty control for an arbitrary number of stages, with
// occupancy tracking, halt/drain handshake and a saturating stall-cycle counter.
module pipe_ctrl_n #(
    parameter int STAGES = 5,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_n_if.slave  bus
);
    localparam int OCC_W = $clog2(STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i < STAGES; i++) begin
            n = n + {{(OCC_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] valid_nxt_s;
    logic [STAGES-1:0] hold_s;
    logic [STAGES-1:0] kill_s;
    logic [CNT_W-1:0]  stall_cnt_r;

    // Hold propagates from older (high index) to younger stages; a flush kills its stage and all younger ones.
    always_comb begin
        logic hold_acc;
        logic kill_acc;
        hold_acc = 1'b0;
        kill_acc = 1'b0;
        hold_s   = '0;
        kill_s   = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            hold_acc  = hold_acc | bus.stall[i] | bus.extend[i];
            kill_acc  = kill_acc | bus.flush[i];
            hold_s[i] = hold_acc;
            kill_s[i] = kill_acc;
        end
    end

    // Next validity: a held stage keeps its bit unless killed; a stage right behind a hold boundary takes a bubble.
    always_comb begin
        valid_nxt_s = valid_r;
        if (hold_s[0]) begin
            valid_nxt_s[0] = valid_r[0] & ~kill_s[0];
        end else begin
            valid_nxt_s[0] = bus.src_valid & ~bus.halt_req;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (hold_s[i]) begin
                valid_nxt_s[i] = valid_r[i] & ~kill_s[i];
            end else if (hold_s[i-1]) begin
                valid_nxt_s[i] = 1'b0;
            end else begin
                valid_nxt_s[i] = valid_r[i-1] & ~kill_s[i-1];
            end
        end
    end

    // Per-stage valid flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
        end else begin
            valid_r <= valid_nxt_s;
        end
    end

    // Stall-cycle counter: clear wins over increment, increment stops at all ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= '0;
        end else if (bus.cnt_clr) begin
            stall_cnt_r <= '0;
        end else if (hold_s[0] && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.keep      = hold_s;
    assign bus.throw     = kill_s;
    assign bus.dirty_now = ~valid_r | kill_s;
    assign bus.dirty     = ~valid_r;
    assign bus.occupancy = popcount(valid_r);
    assign bus.drained   = bus.halt_req & (valid_r == '0);
    assign bus.stall_cnt = stall_cnt_r;

endmodule
